// File: rtl/rvsoc_reset_pkg.sv
// rvsoc_reset_pkg: shared state encodings and default constants for the SoC reset sequencer
package rvsoc_reset_pkg;
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ASSERT = 2'd1,
    ST_HOLD   = 2'd2,
    ST_DELAY  = 2'd3
  } state_t;
  localparam int unsigned ASSERT_CYCLES_DEF = 16;
  localparam int unsigned RELEASE_DELAY_DEF = 8;
  localparam int unsigned CNT_W_DEF         = 8;
  localparam int unsigned TMR_W             = 16;
endpackage

// File: rtl/sync2_ff.sv
// sync2_ff: two-flop synchronizer for a single asynchronous input
// Ports: i_clk destination clock, i_rst_n sync active-low reset, i_d async input, o_q synchronized output
module sync2_ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta, r_sync;
  always_ff @(posedge i_clk)
    if (!i_rst_n) {r_sync, r_meta} <= {2{RST_VAL}};
    else          {r_sync, r_meta} <= {r_meta, i_d};
  assign o_q = r_sync;
endmodule

// File: rtl/rvsoc_reset_seq.sv
// rvsoc_reset_seq: reset sequencer producing a minimum-width, delayed-release reset for the RISC-V SoC
// Ports: wb_clk clock, wb_rst_n sync active-low reset, hps_req_i HPS level request,
//   key_req_n_i async active-low button request, clr_cnt_i event counter clear,
//   soc_rst_o SoC reset, boot_o release pulse, cause_o {key,hps,power-on},
//   reset_cnt_o saturating event count, state_o FSM state
module rvsoc_reset_seq
  import rvsoc_reset_pkg::*;
#(
  parameter int unsigned ASSERT_CYCLES = ASSERT_CYCLES_DEF,
  parameter int unsigned RELEASE_DELAY = RELEASE_DELAY_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic             wb_clk,
  input  logic             wb_rst_n,
  input  logic             hps_req_i,
  input  logic             key_req_n_i,
  input  logic             clr_cnt_i,
  output logic             soc_rst_o,
  output logic             boot_o,
  output logic [2:0]       cause_o,
  output logic [CNT_W-1:0] reset_cnt_o,
  output logic [1:0]       state_o
);
  localparam logic [TMR_W-1:0] A_LOAD = TMR_W'(ASSERT_CYCLES - 1);
  localparam logic [TMR_W-1:0] D_LOAD = TMR_W'(RELEASE_DELAY - 1);
  state_t           r_state, w_next;
  logic [TMR_W-1:0] r_cnt, w_cnt;
  logic             w_key_sync, w_key_req, w_req, w_done, w_event;
  logic             r_soc_rst, r_boot;
  logic [2:0]       r_cause;
  logic [CNT_W-1:0] r_rcnt;
  sync2_ff #(.RST_VAL(1'b1)) u_key_sync (
    .i_clk   (wb_clk),
    .i_rst_n (wb_rst_n),
    .i_d     (key_req_n_i),
    .o_q     (w_key_sync)
  );
  assign w_key_req = ~w_key_sync;
  assign w_req     = hps_req_i | w_key_req;
  assign w_done    = r_cnt == '0;
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RUN:    if (w_req) w_next = ST_ASSERT;
      ST_ASSERT: if (w_done) w_next = w_req ? ST_HOLD : ST_DELAY;
      ST_HOLD:   if (!w_req) w_next = ST_DELAY;
      ST_DELAY:  w_next = w_req ? ST_ASSERT : w_done ? ST_RUN : ST_DELAY;
      default:   w_next = ST_ASSERT;
    endcase
    // ASSERT is only (re)entered from RUN or DELAY; requests inside ASSERT are absorbed by HOLD
    w_event = (w_next == ST_ASSERT) && (r_state == ST_RUN || r_state == ST_DELAY);
    // one timer serves both phases: reload on phase entry, otherwise count down and park at zero
    w_cnt = w_event ? A_LOAD :
            (w_next == ST_DELAY && r_state != ST_DELAY) ? D_LOAD :
            w_done ? r_cnt : r_cnt - TMR_W'(1);
  end
  always_ff @(posedge wb_clk)
    if (!wb_rst_n) begin
      r_state   <= ST_ASSERT;
      r_cnt     <= A_LOAD;
      r_soc_rst <= 1'b1;
      r_boot    <= 1'b0;
      r_cause   <= 3'b001;
      r_rcnt    <= '0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_cnt;
      r_soc_rst <= w_next != ST_RUN;
      r_boot    <= (r_state == ST_DELAY) && (w_next == ST_RUN);
      if (w_event) r_cause <= {w_key_req, hps_req_i, 1'b0};
      r_rcnt    <= clr_cnt_i ? '0 : (w_event && !(&r_rcnt)) ? r_rcnt + CNT_W'(1) : r_rcnt;
    end
  assign soc_rst_o   = r_soc_rst;
  assign boot_o      = r_boot;
  assign cause_o     = r_cause;
  assign reset_cnt_o = r_rcnt;
  assign state_o     = r_state;
endmodule

// File: tb/tb_rvsoc_reset_seq.sv
// tb_rvsoc_reset_seq: table-driven and randomized self-checking bench for rvsoc_reset_seq
module tb_rvsoc_reset_seq;
  localparam int AC = 16;
  localparam int RD = 8;
  logic wb_clk = 1'b0, wb_rst_n = 1'b0, hps_req_i = 1'b0, key_req_n_i = 1'b1, clr_cnt_i = 1'b0;
  logic soc_rst_o, boot_o, s_soc, s_boot;
  logic [2:0] cause_o, s_cause;
  logic [7:0] reset_cnt_o;
  logic [1:0] s_cnt, state_o, s_state;
  int n_chk = 0, n_fail = 0;
  always #5 wb_clk = ~wb_clk;
  rvsoc_reset_seq u_dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .hps_req_i(hps_req_i), .key_req_n_i(key_req_n_i),
    .clr_cnt_i(clr_cnt_i), .soc_rst_o(soc_rst_o), .boot_o(boot_o), .cause_o(cause_o),
    .reset_cnt_o(reset_cnt_o), .state_o(state_o)
  );
  rvsoc_reset_seq #(.CNT_W(2)) u_sat (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .hps_req_i(hps_req_i), .key_req_n_i(key_req_n_i),
    .clr_cnt_i(clr_cnt_i), .soc_rst_o(s_soc), .boot_o(s_boot), .cause_o(s_cause),
    .reset_cnt_o(s_cnt), .state_o(s_state)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int sat(input int v, input int mx);
    return v > mx ? mx : v;
  endfunction
  // reference model: remaining mandatory reset time and remaining release time, as plain counts
  bit m_high = 1'b1, m_boot = 1'b0, chk_en = 1'b0;
  int m_min = AC, m_rel = 0, m_cnt = 0;
  logic [2:0] m_cause = 3'b001;
  bit kq [2] = '{1'b1, 1'b1};
  always @(posedge wb_clk) begin
    bit kr, req, ev;
    kr = !kq[1];
    kq[1] = kq[0];
    kq[0] = key_req_n_i;
    req = hps_req_i | kr;
    ev = 1'b0;
    m_boot = 1'b0;
    if (!wb_rst_n) begin
      m_high = 1'b1; m_min = AC; m_rel = 0; m_cause = 3'b001; m_cnt = 0; kq = '{1'b1, 1'b1};
    end else begin
      if (!m_high) ev = req;
      else if (m_min > 0) begin
        if (m_min == 1) begin m_min = 0; m_rel = req ? 0 : RD; end
        else m_min--;
      end
      else if (m_rel == 0) begin if (!req) m_rel = RD; end
      else if (req) ev = 1'b1;
      else if (m_rel == 1) begin m_rel = 0; m_high = 1'b0; m_boot = 1'b1; end
      else m_rel--;
      if (ev) begin m_high = 1'b1; m_min = AC; m_rel = 0; m_cause = {kr, hps_req_i, 1'b0}; end
      m_cnt = clr_cnt_i ? 0 : m_cnt + int'(ev);
    end
    chk_en = 1'b1;
  end
  always @(negedge wb_clk) if (chk_en) begin
    logic [1:0] es;
    es = !m_high ? 2'd0 : m_min > 0 ? 2'd1 : m_rel == 0 ? 2'd2 : 2'd3;
    chk("m_soc", soc_rst_o, m_high);
    chk("m_boot", boot_o, m_boot);
    chk("m_cause", cause_o, m_cause);
    chk("m_state", state_o, es);
    chk("m_cnt", reset_cnt_o, sat(m_cnt, 255));
    chk("m_cnt_sat", s_cnt, sat(m_cnt, 3));
  end
  typedef struct {
    string nm;
    int h_at, h_len, h2_at, k_at, k_len;
    int rise, high, ev;
    logic [2:0] cause;
  } vec_t;
  vec_t vecs [7];
  vec_t idle;
  task automatic run_vec(input vec_t v);
    int rise, high, boots;
    bit seen;
    logic [7:0] c0;
    c0 = reset_cnt_o;
    seen = soc_rst_o;
    rise = soc_rst_o ? 0 : -1;
    high = int'(soc_rst_o);
    boots = 0;
    for (int t = 0; t < 400; t++) begin
      hps_req_i = (t >= v.h_at && t < v.h_at + v.h_len) || t == v.h2_at;
      key_req_n_i = !(t >= v.k_at && t < v.k_at + v.k_len);
      @(negedge wb_clk);
      if (soc_rst_o) begin
        if (!seen) rise = t + 1;
        seen = 1'b1;
        high++;
      end
      boots += int'(boot_o);
      if (seen && !soc_rst_o) break;
    end
    hps_req_i = 1'b0;
    key_req_n_i = 1'b1;
    chk({v.nm, "_rise"}, rise, v.rise);
    chk({v.nm, "_high"}, high, v.high);
    chk({v.nm, "_boots"}, boots, 1);
    chk({v.nm, "_cause"}, cause_o, v.cause);
    chk({v.nm, "_events"}, reset_cnt_o - c0, v.ev);
    repeat (3) @(negedge wb_clk);
  endtask
  initial begin
    int hl, kl, rl, w;
    idle    = '{"power_on",    -1, 0, -1, -1, 0, 0, 24, 0, 3'b001};
    vecs[0] = '{"hps_pulse",    0, 1, -1, -1, 0, 1, 24, 1, 3'b010};
    vecs[1] = '{"hps_hold100",  0, 100, -1, -1, 0, 1, 108, 1, 3'b010};
    vecs[2] = '{"hps_len16",    0, 16, -1, -1, 0, 1, 24, 1, 3'b010};
    vecs[3] = '{"hps_len17",    0, 17, -1, -1, 0, 1, 25, 1, 3'b010};
    vecs[4] = '{"hps_delay5",   0, 1, 21, -1, 0, 1, 45, 2, 3'b010};
    vecs[5] = '{"key_pulse",   -1, 0, -1, 0, 1, 3, 24, 1, 3'b100};
    vecs[6] = '{"key_hps",      2, 1, -1, 0, 1, 3, 24, 1, 3'b110};
    repeat (3) @(negedge wb_clk);
    chk("rst_soc", soc_rst_o, 1);
    chk("rst_boot", boot_o, 0);
    chk("rst_cause", cause_o, 3'b001);
    chk("rst_cnt", reset_cnt_o, 0);
    chk("rst_state", state_o, 1);
    wb_rst_n = 1'b1;
    run_vec(idle);
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);
    chk("sat_cnt", s_cnt, 3);
    chk("full_cnt", reset_cnt_o, 8);
    hps_req_i = 1'b1;
    clr_cnt_i = 1'b1;
    @(negedge wb_clk);
    hps_req_i = 1'b0;
    clr_cnt_i = 1'b0;
    chk("clr_wins", reset_cnt_o, 0);
    chk("clr_wins_sat", s_cnt, 0);
    chk("clr_event_soc", soc_rst_o, 1);
    w = 0;
    while (soc_rst_o && w < 100) begin @(negedge wb_clk); w++; end
    chk("clr_event_release", soc_rst_o, 0);
    hps_req_i = 1'b1;
    @(negedge wb_clk);
    hps_req_i = 1'b0;
    repeat (5) @(negedge wb_clk);
    wb_rst_n = 1'b0;
    repeat (2) @(negedge wb_clk);
    wb_rst_n = 1'b1;
    idle.nm = "mid_reset";
    run_vec(idle);
    hl = 0; kl = 0; rl = 0;
    repeat (3000) begin
      if (hl == 0) begin hps_req_i = ($urandom_range(0, 4) == 0); hl = $urandom_range(1, 30); end
      hl--;
      if (kl == 0) begin key_req_n_i = ($urandom_range(0, 9) != 0); kl = $urandom_range(1, 5); end
      kl--;
      clr_cnt_i = ($urandom_range(0, 49) == 0);
      if (rl > 0) rl--;
      else if ($urandom_range(0, 499) == 0) rl = $urandom_range(1, 3);
      wb_rst_n = (rl == 0);
      @(negedge wb_clk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rvsoc_reset_seq.md
RVSOC_RESET_SEQ -- requirements
Module: rvsoc_reset_seq

Interface
REQ-001 Parameter ASSERT_CYCLES, default 16, minimum cycles soc_rst_o is held high per reset event (legal 1..65535).
REQ-002 Parameter RELEASE_DELAY, default 8, cycles between all requests clearing and soc_rst_o deassertion (legal 1..65535).
REQ-003 Parameter CNT_W, default 8, width of reset_cnt_o.
REQ-004 wb_clk  in  1  single clock for all logic.
REQ-005 wb_rst_n  in  1  reset, synchronous and active-low.
REQ-006 hps_req_i  in  1  level reset request from the HPS PIO, synchronous to wb_clk, active high.
REQ-007 key_req_n_i  in  1  debounced push-button request, asynchronous to wb_clk, active low.
REQ-008 clr_cnt_i  in  1  one-cycle pulse, clears reset_cnt_o.
REQ-009 soc_rst_o  out  1  registered reset to the RISC-V SoC, active high.
REQ-010 boot_o  out  1  one-cycle pulse on the cycle soc_rst_o falls.
REQ-011 cause_o  out  3  cause of the last reset: bit0 power-on, bit1 HPS, bit2 key.
REQ-012 reset_cnt_o  out  CNT_W  count of reset events since power-on or last clear, saturating.
REQ-013 state_o  out  2  current FSM state encoding, for status/LED.

Function
REQ-014 key_req_n_i SHALL pass through a 2-flop synchronizer; key_req = inverted synchronized value; added latency 2 cycles.
REQ-015 Any request (req) SHALL mean hps_req_i OR key_req.
REQ-016 FSM states SHALL be RUN(0), ASSERT(1), HOLD(2), DELAY(3); soc_rst_o SHALL be 1 in every state except RUN.
REQ-017 ASSERT: down-counter loaded with ASSERT_CYCLES-1 on entry; when it reaches 0, go to HOLD if req else DELAY; total high time in ASSERT = ASSERT_CYCLES cycles exactly.
REQ-018 HOLD: remain while req; on req=0 go to DELAY.
REQ-019 DELAY: counter loaded with RELEASE_DELAY-1 on entry; req=1 in any DELAY cycle SHALL return to ASSERT (counter reloaded, new reset event); counter 0 with req=0 goes to RUN.
REQ-020 RUN: req=1 SHALL transition to ASSERT next cycle; soc_rst_o rises on that edge (1-cycle latency from hps_req_i, 3 from key_req_n_i).
REQ-021 Reset event = each entry into ASSERT from RUN or DELAY; SHALL increment reset_cnt_o, saturating at all-ones (no wrap).
REQ-022 On each reset event cause_o SHALL be overwritten with {key_req, hps_req_i, 0}; both bits set when both requests are simultaneous.
REQ-023 clr_cnt_i coincident with an increment: clear SHALL win (result 0).
REQ-024 boot_o SHALL assert exactly in the first RUN cycle after DELAY, never otherwise.
REQ-025 A request arriving during ASSERT SHALL NOT extend or restart ASSERT; it is absorbed via HOLD.
REQ-026 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-027 wb_rst_n=0 SHALL force state ASSERT with counter ASSERT_CYCLES-1, soc_rst_o=1, boot_o=0, cause_o=3'b001, reset_cnt_o=0, synchronizer flops=1 (key released).
REQ-028 wb_rst_n asserted mid-sequence SHALL abort the sequence; a full ASSERT_CYCLES period follows reset release.
REQ-029 Power-on exit from ASSERT SHALL NOT count as a reset event.

Structure
REQ-030 State encodings and default parameter constants SHALL live in a shared package, rvsoc_reset_pkg.
REQ-031 Synchronizer SHALL be a separate sub-module, sync2_ff, reused for any future async input.
REQ-032 Single counter sized to 16 bits shared between ASSERT and DELAY.

Verification
REQ-033 Power-on: release wb_rst_n, no requests -> soc_rst_o high exactly 16+8=24 cycles, boot_o 1 pulse, cause_o=001, reset_cnt_o=0.
REQ-034 HPS pulse 1 cycle in RUN -> soc_rst_o high 24 cycles from next edge, cause_o=010, reset_cnt_o=1.
REQ-035 hps_req_i held 100 cycles -> soc_rst_o high 100+8 cycles, single event counted.
REQ-036 hps_req_i re-pulsed on DELAY cycle 5 -> new ASSERT of 16, reset_cnt_o increments to 2, boot_o only once.
REQ-037 CNT_W=2, 5 events -> reset_cnt_o stays 3; clr_cnt_i together with an event -> 0.
REQ-038 key_req_n_i low 1 cycle asynchronous, simultaneous hps pulse -> cause_o=110, latency rules of REQ-020 met.
